// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles the requester-side channel handshake and the memory-side
// request/acknowledge bus of the shared memory port arbiter.
//
// Channel side (flattened, channel k at slice [k*W +: W]):
//   ch_req, ch_rw, ch_addr, ch_size, ch_wdata   requester -> arbiter
//   ch_rdata, ch_done, ch_err                   arbiter -> requester
// Memory side:
//   mem_req, mem_rw, mem_addr, mem_be, mem_wdata  arbiter -> slave
//   mem_rdata, mem_ack                            slave -> arbiter
//
// modport master : the arbiter's view (it masters the memory bus)
// modport slave  : the surrounding system's view (requesters + memory)
interface bus_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int XLEN   = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_rw;
  logic [NUM_CH*XLEN-1:0]   ch_addr;
  logic [NUM_CH*2-1:0]      ch_size;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*DATA_W-1:0] ch_rdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;

  logic                     mem_req;
  logic                     mem_rw;
  logic [XLEN-1:0]          mem_addr;
  logic [BYTES-1:0]         mem_be;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_ack;

  modport master (
    input  ch_req, ch_rw, ch_addr, ch_size, ch_wdata,
    output ch_rdata, ch_done, ch_err,
    output mem_req, mem_rw, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output ch_req, ch_rw, ch_addr, ch_size, ch_wdata,
    input  ch_rdata, ch_done, ch_err,
    input  mem_req, mem_rw, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter serialising up to NUM_CH requesters onto a single
// memory request/acknowledge bus. Generates byte enables, rejects
// oversized or misaligned accesses without touching the bus, and times
// out slaves that never acknowledge.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous reset, active-high (1 = reset)
//   bus   bus_arbiter_if.master: channel handshake + memory bus
//
// Parameters: NUM_CH (1..8), XLEN, DATA_W (DATA_W/8 a power of two),
//   TIMEOUT (BUSY cycles before error, 0 = never time out).
module bus_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int XLEN    = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.master bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [TW-1:0]     tcount;

  logic              req_q;
  logic              rw_q;
  logic [XLEN-1:0]   addr_q;
  logic [BYTES-1:0]  be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] err_q;
  logic [DATA_W-1:0] rdata_q [NUM_CH];

  logic [XLEN-1:0]   addr_arr  [NUM_CH];
  logic [1:0]        size_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  // Unflatten channel inputs and flatten the per-channel read data.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign addr_arr[k]  = bus.ch_addr[k*XLEN +: XLEN];
    assign size_arr[k]  = bus.ch_size[k*2 +: 2];
    assign wdata_arr[k] = bus.ch_wdata[k*DATA_W +: DATA_W];
    assign bus.ch_rdata[k*DATA_W +: DATA_W] = rdata_q[k];
  end

  assign bus.ch_done   = done_q;
  assign bus.ch_err    = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  // Round-robin pick: scan starting one past the last channel served so
  // the most recently served channel has the lowest priority.
  logic          found;
  logic [GW-1:0] pick;
  logic [GW-1:0] scan_idx;

  always_comb begin
    found    = 1'b0;
    pick     = last_grant;
    scan_idx = last_grant;
    for (int i = 1; i <= NUM_CH; i++) begin
      scan_idx = GW'((int'(last_grant) + i) % NUM_CH);
      if (!found && bus.ch_req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Decode the candidate access: legality, lane offset and byte enables.
  // A legal access is naturally aligned, so the enable window never runs
  // past the top lane.
  logic [XLEN-1:0]  sel_addr;
  logic [1:0]       sel_size;
  logic [BYTES-1:0] sel_be;
  logic             legal;
  int               nbytes;
  int               off;

  always_comb begin
    sel_addr = addr_arr[pick];
    sel_size = size_arr[pick];
    nbytes   = 1 << sel_size;
    off      = int'(sel_addr[OFF_W-1:0]) & (BYTES - 1);
    legal    = (nbytes <= BYTES) &&
               ((sel_addr & XLEN'(nbytes - 1)) == '0);
    sel_be   = '0;
    for (int b = 0; b < BYTES; b++) begin
      sel_be[b] = (b >= off) && (b < off + nbytes);
    end
  end

  // Main FSM. ch_done is a pulse that is cleared every cycle and set only
  // on the transition into RESP; ch_err and ch_rdata are sticky per channel.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_CH - 1);
      tcount     <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        rdata_q[k] <= '0;
      end
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            rw_q    <= bus.ch_rw[pick];
            addr_q  <= sel_addr & ~XLEN'(BYTES - 1);
            wdata_q <= wdata_arr[pick];
            tcount  <= '0;
            if (legal) begin
              be_q  <= sel_be;
              req_q <= 1'b1;
              state <= BUSY;
            end else begin
              be_q         <= '0;
              done_q[pick] <= 1'b1;
              err_q[pick]  <= 1'b1;
              state        <= RESP;
            end
          end
        end

        BUSY: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            if (!rw_q) begin
              rdata_q[grant] <= bus.mem_rdata;
            end
            done_q[grant] <= 1'b1;
            err_q[grant]  <= 1'b0;
            state         <= RESP;
          end else if (TIMEOUT != 0 && tcount == TW'(TIMEOUT - 1)) begin
            req_q         <= 1'b0;
            done_q[grant] <= 1'b1;
            err_q[grant]  <= 1'b1;
            state         <= RESP;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end

        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed bench for bus_arbiter. A 4-channel instance (TIMEOUT=8) covers
// reads, writes, round-robin order, illegal accesses, timeout and reset;
// a 2-channel instance with TIMEOUT=0 covers the disabled timeout.
module tb_bus_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_CH(4), .XLEN(32), .DATA_W(32)) u_if ();
  bus_arbiter_if #(.NUM_CH(2), .XLEN(32), .DATA_W(32)) z_if ();

  bus_arbiter #(.NUM_CH(4), .XLEN(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (u_if)
  );

  bus_arbiter #(.NUM_CH(2), .XLEN(32), .DATA_W(32), .TIMEOUT(0)) dut_z (
    .clk (clk),
    .rstn(rstn),
    .bus (z_if)
  );

  task automatic clear_inputs();
    u_if.ch_req    = '0;
    u_if.ch_rw     = '0;
    u_if.ch_addr   = '0;
    u_if.ch_size   = '0;
    u_if.ch_wdata  = '0;
    u_if.mem_rdata = '0;
    u_if.mem_ack   = 1'b0;
    z_if.ch_req    = '0;
    z_if.ch_rw     = '0;
    z_if.ch_addr   = '0;
    z_if.ch_size   = '0;
    z_if.ch_wdata  = '0;
    z_if.mem_rdata = '0;
    z_if.mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic rw, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata);
    u_if.ch_rw[k]              = rw;
    u_if.ch_addr[k*32 +: 32]   = addr;
    u_if.ch_size[k*2 +: 2]     = size;
    u_if.ch_wdata[k*32 +: 32]  = wdata;
    u_if.ch_req[k]             = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req: got %b want 0", u_if.mem_req); else passed++;
    total++; if (u_if.ch_done !== 4'b0) $display("[TB] FAIL reset_ch_done: got %b want 0000", u_if.ch_done); else passed++;
    total++; if (u_if.ch_err !== 4'b0) $display("[TB] FAIL reset_ch_err: got %b want 0000", u_if.ch_err); else passed++;
    total++; if (u_if.mem_be !== 4'b0) $display("[TB] FAIL reset_mem_be: got %b want 0000", u_if.mem_be); else passed++;
    total++; if (u_if.mem_addr !== 32'h0) $display("[TB] FAIL reset_mem_addr: got %h want 0", u_if.mem_addr); else passed++;
    total++; if (u_if.mem_wdata !== 32'h0) $display("[TB] FAIL reset_mem_wdata: got %h want 0", u_if.mem_wdata); else passed++;
    total++; if (u_if.ch_rdata !== 128'h0) $display("[TB] FAIL reset_ch_rdata: got %h want 0", u_if.ch_rdata); else passed++;
    total++; if (z_if.mem_req !== 1'b0) $display("[TB] FAIL reset_z_mem_req: got %b want 0", z_if.mem_req); else passed++;
    rstn = 1'b0;
    @(negedge clk);
    total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL idle_no_req: got %b want 0", u_if.mem_req); else passed++;
  endtask

  task automatic test_single_read();
    do_reset();
    set_ch(0, 1'b0, 32'h100, 2'd2, 32'h0);
    @(negedge clk);
    total++; if (u_if.mem_req !== 1'b1) $display("[TB] FAIL read_mem_req: got %b want 1", u_if.mem_req); else passed++;
    total++; if (u_if.mem_be !== 4'b1111) $display("[TB] FAIL read_mem_be: got %b want 1111", u_if.mem_be); else passed++;
    total++; if (u_if.mem_addr !== 32'h100) $display("[TB] FAIL read_mem_addr: got %h want 100", u_if.mem_addr); else passed++;
    total++; if (u_if.mem_rw !== 1'b0) $display("[TB] FAIL read_mem_rw: got %b want 0", u_if.mem_rw); else passed++;
    repeat (2) begin
      @(negedge clk);
      total++; if (u_if.mem_req !== 1'b1 || u_if.ch_done !== 4'b0) $display("[TB] FAIL read_hold: req %b done %b want 1 0000", u_if.mem_req, u_if.ch_done); else passed++;
    end
    u_if.mem_rdata = 32'hDEADBEEF;
    u_if.mem_ack   = 1'b1;
    @(negedge clk);
    u_if.mem_ack   = 1'b0;
    u_if.ch_req[0] = 1'b0;
    total++; if (u_if.ch_done !== 4'b0001) $display("[TB] FAIL read_done: got %b want 0001", u_if.ch_done); else passed++;
    total++; if (u_if.ch_err !== 4'b0000) $display("[TB] FAIL read_err: got %b want 0000", u_if.ch_err); else passed++;
    total++; if (u_if.ch_rdata[31:0] !== 32'hDEADBEEF) $display("[TB] FAIL read_rdata: got %h want deadbeef", u_if.ch_rdata[31:0]); else passed++;
    total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL read_req_drop: got %b want 0", u_if.mem_req); else passed++;
    @(negedge clk);
    total++; if (u_if.ch_done !== 4'b0) $display("[TB] FAIL read_done_pulse: got %b want 0000", u_if.ch_done); else passed++;
  endtask

  // Slave acks in the first BUSY cycle; grants must rotate and each
  // done must follow the previous one by exactly three cycles.
  task automatic test_round_robin(input int n_act, input int n_done);
    int         seen;
    int         last_cyc;
    logic [3:0] exp;
    seen     = 0;
    last_cyc = 0;
    do_reset();
    for (int k = 0; k < n_act; k++) set_ch(k, 1'b0, 32'h400 + 32'(k*16), 2'd2, 32'h0);
    for (int cyc = 0; cyc < 40 && seen < n_done; cyc++) begin
      @(negedge clk);
      if (u_if.ch_done !== 4'b0) begin
        exp = 4'(1 << (seen % n_act));
        total++; if (u_if.ch_done !== exp) $display("[TB] FAIL rr%0d_order[%0d]: got %b want %b", n_act, seen, u_if.ch_done, exp); else passed++;
        if (seen > 0) begin
          total++; if (cyc - last_cyc !== 3) $display("[TB] FAIL rr%0d_spacing[%0d]: got %0d want 3", n_act, seen, cyc - last_cyc); else passed++;
        end
        last_cyc = cyc;
        seen++;
      end
      u_if.mem_ack = (u_if.mem_req === 1'b1 && u_if.mem_ack === 1'b0);
    end
    total++; if (seen !== n_done) $display("[TB] FAIL rr%0d_count: got %0d want %0d", n_act, seen, n_done); else passed++;
  endtask

  task automatic test_byte_half_write();
    logic [31:0] addrs [2] = '{32'h203, 32'h202};
    logic [1:0]  sizes [2] = '{2'd0, 2'd1};
    logic [31:0] wdats [2] = '{32'hAA000000, 32'hBBCC0000};
    logic [3:0]  bes   [2] = '{4'b1000, 4'b1100};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_ch(1, 1'b1, addrs[i], sizes[i], wdats[i]);
      @(negedge clk);
      total++; if (u_if.mem_req !== 1'b1) $display("[TB] FAIL wr%0d_mem_req: got %b want 1", i, u_if.mem_req); else passed++;
      total++; if (u_if.mem_be !== bes[i]) $display("[TB] FAIL wr%0d_mem_be: got %b want %b", i, u_if.mem_be, bes[i]); else passed++;
      total++; if (u_if.mem_addr !== 32'h200) $display("[TB] FAIL wr%0d_mem_addr: got %h want 200", i, u_if.mem_addr); else passed++;
      total++; if (u_if.mem_rw !== 1'b1) $display("[TB] FAIL wr%0d_mem_rw: got %b want 1", i, u_if.mem_rw); else passed++;
      total++; if (u_if.mem_wdata !== wdats[i]) $display("[TB] FAIL wr%0d_mem_wdata: got %h want %h", i, u_if.mem_wdata, wdats[i]); else passed++;
      u_if.mem_rdata = 32'h12345678;
      u_if.mem_ack   = 1'b1;
      @(negedge clk);
      u_if.mem_ack   = 1'b0;
      u_if.ch_req[1] = 1'b0;
      total++; if (u_if.ch_done !== 4'b0010) $display("[TB] FAIL wr%0d_done: got %b want 0010", i, u_if.ch_done); else passed++;
      total++; if (u_if.ch_err !== 4'b0000) $display("[TB] FAIL wr%0d_err: got %b want 0000", i, u_if.ch_err); else passed++;
      total++; if (u_if.ch_rdata[63:32] !== 32'h0) $display("[TB] FAIL wr%0d_rdata_kept: got %h want 0", i, u_if.ch_rdata[63:32]); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3] = '{32'h201, 32'h102, 32'h100};
    logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
    do_reset();
    set_ch(0, 1'b0, 32'h100, 2'd2, 32'h0);
    @(negedge clk);
    u_if.mem_rdata = 32'h5A5A1234;
    u_if.mem_ack   = 1'b1;
    @(negedge clk);
    u_if.mem_ack   = 1'b0;
    u_if.ch_req[0] = 1'b0;
    total++; if (u_if.ch_rdata[31:0] !== 32'h5A5A1234) $display("[TB] FAIL ill_setup_rdata: got %h want 5a5a1234", u_if.ch_rdata[31:0]); else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b0, addrs[i], sizes[i], 32'h0);
      @(negedge clk);
      total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL ill%0d_mem_req: got %b want 0", i, u_if.mem_req); else passed++;
      total++; if (u_if.ch_done !== 4'b0001) $display("[TB] FAIL ill%0d_done: got %b want 0001", i, u_if.ch_done); else passed++;
      total++; if (u_if.ch_err !== 4'b0001) $display("[TB] FAIL ill%0d_err: got %b want 0001", i, u_if.ch_err); else passed++;
      total++; if (u_if.ch_rdata[31:0] !== 32'h5A5A1234) $display("[TB] FAIL ill%0d_rdata: got %h want 5a5a1234", i, u_if.ch_rdata[31:0]); else passed++;
      u_if.ch_req[0] = 1'b0;
      @(negedge clk);
      total++; if (u_if.ch_done !== 4'b0 || u_if.mem_req !== 1'b0) $display("[TB] FAIL ill%0d_after: done %b req %b want 0000 0", i, u_if.ch_done, u_if.mem_req); else passed++;
      total++; if (u_if.ch_err !== 4'b0001) $display("[TB] FAIL ill%0d_err_hold: got %b want 0001", i, u_if.ch_err); else passed++;
    end
    set_ch(0, 1'b0, 32'h100, 2'd2, 32'h0);
    @(negedge clk);
    u_if.mem_rdata = 32'h0;
    u_if.mem_ack   = 1'b1;
    @(negedge clk);
    u_if.mem_ack   = 1'b0;
    u_if.ch_req[0] = 1'b0;
    total++; if (u_if.ch_done !== 4'b0001 || u_if.ch_err !== 4'b0000) $display("[TB] FAIL ill_err_clear: done %b err %b want 0001 0000", u_if.ch_done, u_if.ch_err); else passed++;
  endtask

  task automatic test_timeout();
    int high;
    bit got;
    high = 0;
    got  = 1'b0;
    do_reset();
    set_ch(2, 1'b0, 32'h300, 2'd2, 32'h0);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (u_if.ch_done !== 4'b0) got = 1'b1;
      else if (u_if.mem_req === 1'b1) high++;
    end
    total++; if (got !== 1'b1) $display("[TB] FAIL to_done_seen: got %b want 1", got); else passed++;
    total++; if (high !== 8) $display("[TB] FAIL to_req_cycles: got %0d want 8", high); else passed++;
    total++; if (u_if.ch_done !== 4'b0100) $display("[TB] FAIL to_done: got %b want 0100", u_if.ch_done); else passed++;
    total++; if (u_if.ch_err !== 4'b0100) $display("[TB] FAIL to_err: got %b want 0100", u_if.ch_err); else passed++;
    total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL to_req_drop: got %b want 0", u_if.mem_req); else passed++;
    u_if.ch_req[2] = 1'b0;
    u_if.mem_rdata = 32'hFFFFFFFF;
    u_if.mem_ack   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++; if (u_if.ch_done !== 4'b0 || u_if.mem_req !== 1'b0) $display("[TB] FAIL to_late_ack: done %b req %b want 0000 0", u_if.ch_done, u_if.mem_req); else passed++;
    end
    u_if.mem_ack = 1'b0;
    total++; if (u_if.ch_rdata[95:64] !== 32'h0) $display("[TB] FAIL to_rdata: got %h want 0", u_if.ch_rdata[95:64]); else passed++;
    total++; if (u_if.ch_err !== 4'b0100) $display("[TB] FAIL to_err_hold: got %b want 0100", u_if.ch_err); else passed++;
  endtask

  task automatic test_timeout_disabled();
    int high;
    int dones;
    high  = 0;
    dones = 0;
    do_reset();
    z_if.ch_rw[0]        = 1'b0;
    z_if.ch_addr[31:0]   = 32'h80;
    z_if.ch_size[1:0]    = 2'd2;
    z_if.ch_req[0]       = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (z_if.mem_req === 1'b1) high++;
      if (z_if.ch_done !== 2'b0) dones++;
    end
    total++; if (high !== 1000) $display("[TB] FAIL nto_req_cycles: got %0d want 1000", high); else passed++;
    total++; if (dones !== 0) $display("[TB] FAIL nto_no_done: got %0d want 0", dones); else passed++;
    z_if.mem_rdata = 32'h13579BDF;
    z_if.mem_ack   = 1'b1;
    @(negedge clk);
    z_if.mem_ack   = 1'b0;
    z_if.ch_req[0] = 1'b0;
    total++; if (z_if.ch_done !== 2'b01) $display("[TB] FAIL nto_done: got %b want 01", z_if.ch_done); else passed++;
    total++; if (z_if.ch_err !== 2'b00) $display("[TB] FAIL nto_err: got %b want 00", z_if.ch_err); else passed++;
    total++; if (z_if.ch_rdata[31:0] !== 32'h13579BDF) $display("[TB] FAIL nto_rdata: got %h want 13579bdf", z_if.ch_rdata[31:0]); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    set_ch(0, 1'b0, 32'h100, 2'd2, 32'h0);
    set_ch(1, 1'b0, 32'h104, 2'd2, 32'h0);
    @(negedge clk);
    total++; if (u_if.mem_req !== 1'b1 || u_if.mem_addr !== 32'h100) $display("[TB] FAIL mid_first_grant: req %b addr %h want 1 100", u_if.mem_req, u_if.mem_addr); else passed++;
    u_if.mem_rdata = 32'h11112222;
    u_if.mem_ack   = 1'b1;
    @(negedge clk);
    u_if.mem_ack   = 1'b0;
    total++; if (u_if.ch_done !== 4'b0001) $display("[TB] FAIL mid_first_done: got %b want 0001", u_if.ch_done); else passed++;
    repeat (2) @(negedge clk);
    total++; if (u_if.mem_req !== 1'b1 || u_if.mem_addr !== 32'h104) $display("[TB] FAIL mid_second_grant: req %b addr %h want 1 104", u_if.mem_req, u_if.mem_addr); else passed++;
    #2 rstn = 1'b1;
    #1;
    total++; if (u_if.mem_req !== 1'b0) $display("[TB] FAIL mid_rst_req: got %b want 0", u_if.mem_req); else passed++;
    total++; if (u_if.mem_addr !== 32'h0 || u_if.mem_be !== 4'b0) $display("[TB] FAIL mid_rst_bus: addr %h be %b want 0 0000", u_if.mem_addr, u_if.mem_be); else passed++;
    total++; if (u_if.ch_rdata !== 128'h0) $display("[TB] FAIL mid_rst_rdata: got %h want 0", u_if.ch_rdata); else passed++;
    total++; if (u_if.ch_done !== 4'b0 || u_if.ch_err !== 4'b0) $display("[TB] FAIL mid_rst_done_err: done %b err %b want 0000 0000", u_if.ch_done, u_if.ch_err); else passed++;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    total++; if (u_if.mem_req !== 1'b1 || u_if.mem_addr !== 32'h100) $display("[TB] FAIL mid_after_grant: req %b addr %h want 1 100", u_if.mem_req, u_if.mem_addr); else passed++;
    u_if.mem_rdata = 32'h0;
    u_if.mem_ack   = 1'b1;
    @(negedge clk);
    u_if.mem_ack   = 1'b0;
    u_if.ch_req    = '0;
    total++; if (u_if.ch_done !== 4'b0001) $display("[TB] FAIL mid_after_done: got %b want 0001", u_if.ch_done); else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting bus_arbiter bench");
    test_reset();
    test_single_read();
    test_round_robin(2, 4);
    test_round_robin(4, 5);
    test_byte_half_write();
    test_illegal();
    test_timeout();
    test_timeout_disabled();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
